// File: rtl/morse_pkg.sv
// Shared constants for the Morse decoder: FSM encoding, element timing and the
// letter code table consumed by the pattern lookup.
package morse_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MARK  = 2'd1;
  localparam logic [1:0] ST_SPACE = 2'd2;
  localparam logic [1:0] ST_ERROR = 2'd3;

  localparam logic [2:0] MAX_ELEMENTS = 3'd4;
  localparam logic [2:0] DOT_UNITS    = 3'd1;
  localparam logic [2:0] DASH_UNITS   = 3'd3;
  localparam logic [2:0] HIGH_SAT     = 3'd4;

  localparam int NUM_LETTERS = 8;

  typedef struct packed {
    logic [2:0] count;
    logic [3:0] pattern;
  } letter_code_t;

  // Pattern is right-aligned: the newest element sits in bit 0, dash=1, dot=0.
  function automatic letter_code_t letter_code(input logic [2:0] idx);
    letter_code_t code;
    case (idx)
      3'd0:    code = '{count: 3'd2, pattern: 4'b0001};
      3'd1:    code = '{count: 3'd4, pattern: 4'b1000};
      3'd2:    code = '{count: 3'd4, pattern: 4'b1010};
      3'd3:    code = '{count: 3'd3, pattern: 4'b0100};
      3'd4:    code = '{count: 3'd1, pattern: 4'b0000};
      3'd5:    code = '{count: 3'd4, pattern: 4'b0010};
      3'd6:    code = '{count: 3'd3, pattern: 4'b0110};
      default: code = '{count: 3'd4, pattern: 4'b0000};
    endcase
    return code;
  endfunction

endpackage

// File: rtl/morse_decoder_if.sv
// Signal bundle between the Morse line driver and the decoder.
// Enable/morseBit are sampled only when Enable=1; letterValid and symbolError
// are unacknowledged one-cycle pulses, never both high, letterIndex qualified by letterValid.
interface morse_decoder_if;
  logic       Enable;
  logic       morseBit;
  logic [2:0] letterIndex;
  logic       letterValid;
  logic       symbolError;
  logic       busy;
  logic [1:0] dbgState;

  modport master (
    output Enable, morseBit,
    input  letterIndex, letterValid, symbolError, busy, dbgState
  );

  modport slave (
    input  Enable, morseBit,
    output letterIndex, letterValid, symbolError, busy, dbgState
  );
endinterface

// File: rtl/morse_pattern_lookup.sv
// Combinational match of an accumulated element pattern against the letter table.
module morse_pattern_lookup
  import morse_pkg::*;
(
  input  logic [2:0] i_elem_count,
  input  logic [3:0] i_pattern,
  output logic [2:0] o_index,
  output logic       o_hit
);

  letter_code_t w_key;
  assign w_key = '{count: i_elem_count, pattern: i_pattern};

  always_comb begin
    o_index = 3'd0;
    o_hit   = 1'b0;
    for (int i = 0; i < NUM_LETTERS; i++) begin
      if (letter_code(3'(i)) == w_key) begin
        o_index = 3'(i);
        o_hit   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/morse_decoder.sv
// Morse line decoder: times marks/spaces in Enable ticks, accumulates dots and
// dashes, and resolves a letter after GAP_UNITS low units.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int GAP_UNITS = 3
) (
  input  logic            Clock,
  input  logic            Reset,
  morse_decoder_if.slave  bus
);

  localparam logic [2:0] GAP = 3'(GAP_UNITS);

  logic [1:0] r_state;
  logic [2:0] r_high_cnt;
  logic [2:0] r_low_cnt;
  logic [2:0] r_elem_cnt;
  logic [3:0] r_pattern;
  logic [2:0] r_letter_index;
  logic       r_letter_valid;
  logic       r_symbol_error;

  logic [2:0] w_lookup_index;
  logic       w_lookup_hit;
  logic       w_elem_ok;
  logic       w_is_dash;
  logic       w_gap_done;

  morse_pattern_lookup u_lookup (
    .i_elem_count (r_elem_cnt),
    .i_pattern    (r_pattern),
    .o_index      (w_lookup_index),
    .o_hit        (w_lookup_hit)
  );

  assign w_is_dash  = (r_high_cnt == DASH_UNITS);
  assign w_elem_ok  = (r_high_cnt == DOT_UNITS) || w_is_dash;
  assign w_gap_done = ((r_low_cnt + 3'd1) >= GAP);

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state        <= ST_IDLE;
      r_high_cnt     <= 3'd0;
      r_low_cnt      <= 3'd0;
      r_elem_cnt     <= 3'd0;
      r_pattern      <= 4'd0;
      r_letter_index <= 3'd0;
      r_letter_valid <= 1'b0;
      r_symbol_error <= 1'b0;
    end else begin
      r_letter_valid <= 1'b0;
      r_symbol_error <= 1'b0;
      if (bus.Enable) begin
        case (r_state)
          ST_IDLE: begin
            if (bus.morseBit) begin
              r_state    <= ST_MARK;
              r_high_cnt <= 3'd1;
            end
          end
          ST_MARK: begin
            if (bus.morseBit) begin
              if (r_high_cnt < HIGH_SAT) r_high_cnt <= r_high_cnt + 3'd1;
            end else if (!w_elem_ok || (r_elem_cnt == MAX_ELEMENTS)) begin
              r_state        <= ST_ERROR;
              r_symbol_error <= 1'b1;
              r_low_cnt      <= 3'd0;
              r_elem_cnt     <= 3'd0;
              r_pattern      <= 4'd0;
            end else begin
              r_state    <= ST_SPACE;
              r_pattern  <= {r_pattern[2:0], w_is_dash};
              r_elem_cnt <= r_elem_cnt + 3'd1;
              r_low_cnt  <= 3'd1;
            end
          end
          ST_SPACE: begin
            if (bus.morseBit) begin
              if (r_low_cnt == 3'd1) begin
                r_state    <= ST_MARK;
                r_high_cnt <= 3'd1;
              end else begin
                r_state        <= ST_ERROR;
                r_symbol_error <= 1'b1;
                r_low_cnt      <= 3'd0;
                r_elem_cnt     <= 3'd0;
                r_pattern      <= 4'd0;
              end
            end else if (w_gap_done) begin
              // Letter boundary: publish the lookup result, then start fresh.
              if (w_lookup_hit) begin
                r_letter_valid <= 1'b1;
                r_letter_index <= w_lookup_index;
              end else begin
                r_symbol_error <= 1'b1;
              end
              r_state    <= ST_IDLE;
              r_low_cnt  <= 3'd0;
              r_elem_cnt <= 3'd0;
              r_pattern  <= 4'd0;
            end else begin
              r_low_cnt <= r_low_cnt + 3'd1;
            end
          end
          default: begin
            if (bus.morseBit) begin
              r_low_cnt <= 3'd0;
            end else if (w_gap_done) begin
              r_state   <= ST_IDLE;
              r_low_cnt <= 3'd0;
            end else begin
              r_low_cnt <= r_low_cnt + 3'd1;
            end
          end
        endcase
      end
    end
  end

  assign bus.letterIndex = r_letter_index;
  assign bus.letterValid = r_letter_valid;
  assign bus.symbolError = r_symbol_error;
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.dbgState    = r_state;

endmodule

// File: tb/tb_morse_decoder.sv
// Directed bench for morse_decoder: driver issues Enable-qualified samples and
// queues expected pulses; a negedge monitor pops and compares each pulse.
module tb_morse_decoder;
  import morse_pkg::*;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_total;
  int   n_bad;
  logic [2:0] model_idx;

  // {letterValid, symbolError, letterIndex}
  logic [4:0] exp_q[$];
  int         exp_cyc_q[$];

  morse_decoder_if bus ();

  morse_decoder #(.GAP_UNITS(3)) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus.slave)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int expv);
    n_total++;
    if (got != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, expv);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [4:0] got;
    logic [4:0] expv;
    int         ec;
    if (rst_n && (bus.letterValid || bus.symbolError)) begin
      got = {bus.letterValid, bus.symbolError, bus.letterIndex};
      if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL unexpected_pulse: got valid=%0b err=%0b idx=%0d, required no pulse",
                 bus.letterValid, bus.symbolError, bus.letterIndex);
      end else begin
        expv = exp_q.pop_front();
        ec   = exp_cyc_q.pop_front();
        check("pulse_value", int'(got), int'(expv));
        check("pulse_cycle", cyc, ec);
      end
    end
  end

  // driver: one Enable tick per sample; kind 1 = letter expected, 2 = error expected
  task automatic send_seq(input logic [15:0] bits, input int n, input int kind,
                          input logic [2:0] idx);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      bus.morseBit = bits[i];
      bus.Enable   = 1'b1;
      if (i == 0 && kind != 0) begin
        if (kind == 1) begin
          exp_q.push_back({1'b1, 1'b0, idx});
          model_idx = idx;
        end else begin
          exp_q.push_back({1'b0, 1'b1, model_idx});
        end
        exp_cyc_q.push_back(cyc + 1);
      end
      @(negedge clk);
      bus.Enable   = 1'b0;
      bus.morseBit = 1'($urandom_range(0, 1));
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    cyc          = 0;
    n_total      = 0;
    n_bad        = 0;
    model_idx    = 3'd0;
    rst_n        = 1'b0;
    bus.Enable   = 1'b0;
    bus.morseBit = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    check("reset_valid", int'(bus.letterValid), 0);
    check("reset_error", int'(bus.symbolError), 0);
    check("reset_index", int'(bus.letterIndex), 0);
    check("reset_busy",  int'(bus.busy), 0);
    check("reset_state", int'(bus.dbgState), int'(ST_IDLE));

    // letters
    send_seq(16'b1000, 4, 1, 3'd4);                       // E
    send_seq(16'b10111000, 8, 1, 3'd0);                   // A
    send_seq(16'b1010101000, 10, 1, 3'd7);                // H
    send_seq(16'b111010101000, 12, 1, 3'd1);              // B
    send_seq(16'b11101011101000, 14, 1, 3'd2);            // C
    send_seq(16'b1110101000, 10, 1, 3'd3);                // D
    send_seq(16'b101011101000, 12, 1, 3'd5);              // F
    send_seq(16'b111011101000, 12, 1, 3'd6);              // G

    // unknown pattern dot-dash-dash
    send_seq(16'b101110111000, 12, 2, 3'd0);

    // bad mark length 2, recover, then E
    send_seq(16'b110, 3, 2, 3'd0);
    send_seq(16'b000, 3, 0, 3'd0);
    send_seq(16'b1000, 4, 1, 3'd4);

    // saturated long mark, recover
    send_seq(16'b111110, 6, 2, 3'd0);
    send_seq(16'b000, 3, 0, 3'd0);

    // mid-gap high: low count 2 < GAP
    send_seq(16'b1001, 4, 2, 3'd0);
    send_seq(16'b000, 3, 0, 3'd0);
    send_seq(16'b10111000, 8, 1, 3'd0);                   // A after recovery

    // five dots overflow, recover, then E
    send_seq(16'b1010101010, 10, 2, 3'd0);
    send_seq(16'b000, 3, 0, 3'd0);
    check("busy_after_recover", int'(bus.busy), 0);
    send_seq(16'b1000, 4, 1, 3'd4);

    // word gap: extra lows produce nothing
    send_seq(16'b1110101000, 10, 1, 3'd3);
    send_seq(16'b000000, 6, 0, 3'd0);

    // reset mid-letter with coincident Enable
    send_seq(16'b101, 3, 0, 3'd0);
    check("busy_mid_letter", int'(bus.busy), 1);
    @(negedge clk);
    rst_n        = 1'b0;
    bus.Enable   = 1'b1;
    bus.morseBit = 1'b1;
    @(negedge clk);
    rst_n      = 1'b1;
    bus.Enable = 1'b0;
    model_idx  = 3'd0;
    check("midreset_busy",  int'(bus.busy), 0);
    check("midreset_index", int'(bus.letterIndex), 0);
    check("midreset_state", int'(bus.dbgState), int'(ST_IDLE));
    send_seq(16'b1000, 4, 1, 3'd4);

    // Enable gating inside a mark
    send_seq(16'b1, 1, 0, 3'd0);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      bus.morseBit = ~bus.morseBit;
      bus.Enable   = 1'b0;
      check("gate_busy",  int'(bus.busy), 1);
      check("gate_state", int'(bus.dbgState), int'(ST_MARK));
      check("gate_index", int'(bus.letterIndex), int'(model_idx));
    end
    send_seq(16'b000, 3, 1, 3'd4);

    repeat (10) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
